rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter and sequencer for a shared 4-to-1 data multiplexer. Four requesters each offer one word with a request/grant handshake. The block picks one requester per transfer in rotating priority and drives the mux select. It registers the selected word into a single-entry output stage with a valid/ready handshake toward the downstream consumer. It sits between independent producers and one shared sink, replacing a fixed-select mux where fair sharing is required.

## Interface
Parameters:
- DATA_W, 8, width of each requester word and of data_o

Ports:
- clk_i  input  1  clock; all registers update on rising edge
- rst_i  input  1  synchronous reset, active high
- req_i  input  4  per-requester request; bit k = requester k holds a valid word
- data_i  input  4*DATA_W  packed words; requester k at bits [k*DATA_W +: DATA_W]
- ready_i  input  1  downstream can accept data_o this cycle
- grant_o  output  4  one-hot, combinational; bit k = requester k's word is sampled at this clock edge
- valid_o  output  1  data_o holds an unconsumed word (registered)
- data_o  output  DATA_W  registered output word
- sel_o  output  2  index of the requester whose word is in data_o (registered)

## Operation
- Output stage states: EMPTY (valid_o=0) and FULL (valid_o=1).
- load = ~rst_i & (req_i != 0) & (~valid_o | ready_i).
  - In EMPTY, a pending request loads.
  - In FULL, a load occurs only on the same cycle the current word is consumed (valid_o & ready_i).
- Priority pointer ptr (2 bits, internal).
  - The winner is the first k with req_i[k]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On load:
  - grant_o = onehot(winner) in that cycle.
  - At the edge: data_o <= data_i[winner], sel_o <= winner, valid_o <= 1, ptr <= winner+1 (mod 4; 3 wraps to 0).
- On consume (valid_o & ready_i) with no load: valid_o <= 0. data_o and sel_o hold their values.
- FULL with ready_i=0: data_o, sel_o and valid_o hold stable. grant_o=0, whatever req_i does.
- grant_o=0 whenever load=0.
- A requester must hold req_i and its data_i stable until it sees its grant bit. It deasserts or presents new data after the granting edge.
- Reset (rst_i=1), at any time including mid-transfer:
  - Next cycle: valid_o=0, data_o=0, sel_o=0, ptr=0.
  - grant_o=0 combinationally while rst_i=1.
  - A word held in the output stage is discarded.

## Timing
- Latency: request accepted at edge N → valid_o=1 with data in cycle N+1.
- Throughput: one word per cycle when ready_i stays high and any req_i is asserted (back-to-back loads).
- Combinational paths into grant_o: req_i, ready_i, rst_i. No combinational path into valid_o, data_o or sel_o.
- Simultaneous consume and load: valid_o stays 1 and data_o is replaced by the new word at the same edge, with no bubble.
- All four requesters asserted continuously with ready_i=1: grants rotate 0,1,2,3,0,… (from ptr=0).
- A single requester asserted continuously is granted every cycle. The pointer advances past it, but it remains the only candidate.

## Test plan
- Reset, then idle: rst_i=1 for 2 cycles, then req_i=0 → valid_o=0, data_o=0, sel_o=0, grant_o=0 for 5 cycles.
- Single request, DATA_W=8: req_i=4'b0100, data word 2 = 8'hA5, ready_i=1 → grant_o=4'b0100 in cycle 0; cycle 1 shows valid_o=1, data_o=8'hA5, sel_o=2.
- Full rotation: req_i=4'b1111 held, words 8'h10/8'h21/8'h32/8'h43, ready_i=1 → sel_o sequence 0,1,2,3,0 on consecutive cycles; grant_o one-hot and rotating.
- Backpressure: load word 8'h55 from requester 1, then ready_i=0 for 4 cycles with req_i=4'b1001 → grant_o=0 and data_o=8'h55 stable throughout. Set ready_i=1 → requester 3 is granted (ptr=2, scan 2,3), then requester 0.
- Wrap-around: after a grant to requester 3, req_i=4'b0011 → requester 0 wins (ptr=0); next cycle requester 1 wins.
- Reset mid-transfer: valid_o=1 with ready_i=0, assert rst_i for 1 cycle → next cycle valid_o=0, sel_o=0. With req_i=4'b1010 afterwards, requester 1 wins (ptr back to 0).

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
// Bundles the requester side and the downstream side of the shared 4-to-1 mux
// arbiter so the arbiter and its environment connect through one port.
//   req_i    : per-requester request (bit k = requester k has a word)
//   data_i   : packed requester words, requester k at [k*DATA_W +: DATA_W]
//   ready_i  : downstream can take data_o this cycle
//   grant_o  : one-hot grant, combinational
//   valid_o  : output stage holds an unconsumed word
//   data_o   : registered output word
//   sel_o    : index of the requester whose word sits in data_o
// Modports: slave = arbiter side, master = requesters/consumer side.
interface rr_mux_arbiter_if #(
   parameter int DATA_W = 8
);
   logic [3:0]          req_i;
   logic [4*DATA_W-1:0] data_i;
   logic                ready_i;
   logic [3:0]          grant_o;
   logic                valid_o;
   logic [DATA_W-1:0]   data_o;
   logic [1:0]          sel_o;

   modport slave (
      input  req_i, data_i, ready_i,
      output grant_o, valid_o, data_o, sel_o
   );

   modport master (
      output req_i, data_i, ready_i,
      input  grant_o, valid_o, data_o, sel_o
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter for four requesters sharing one 4-to-1 data mux. The
// winning word is captured into a single-entry output stage that hands it to
// the downstream consumer with valid/ready.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active high
//   bus   : rr_mux_arbiter_if.slave (req/data in, grant/valid/data/sel out)
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no word held, valid_o=0; any request loads
// FULL  | word held in data_o, valid_o=1; reload only
//       | on the cycle the held word is consumed
module rr_mux_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rr_mux_arbiter_if.slave  bus
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]        r_state;
   logic [1:0]        r_ptr;
   logic [1:0]        r_sel;
   logic [DATA_W-1:0] r_data;

   logic              w_valid;
   logic              w_load;
   logic [1:0]        w_winner;
   logic [1:0]        w_idx;

   assign w_valid = (r_state == FULL);

   // Scan from the farthest offset down to ptr so the nearest requester
   // (in rotating order) is the last assignment and therefore wins.
   always_comb begin
      w_winner = 2'd0;
      w_idx    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_ptr + i[1:0];
         if (bus.req_i[w_idx]) begin
            w_winner = w_idx;
         end
      end
   end

   assign w_load = ~rst_i & (|bus.req_i) & (~w_valid | bus.ready_i);

   assign bus.grant_o = w_load ? (4'b0001 << w_winner) : 4'b0000;
   assign bus.valid_o = w_valid;
   assign bus.data_o  = r_data;
   assign bus.sel_o   = r_sel;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= EMPTY;
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_data  <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_load) begin
                  r_state <= FULL;
                  r_data  <= bus.data_i[w_winner*DATA_W +: DATA_W];
                  r_sel   <= w_winner;
                  r_ptr   <= w_winner + 2'd1;
               end
            end
            default: begin
               // A load here always coincides with consumption of the held
               // word, so the stage refills without a bubble.
               if (w_load) begin
                  r_data <= bus.data_i[w_winner*DATA_W +: DATA_W];
                  r_sel  <= w_winner;
                  r_ptr  <= w_winner + 2'd1;
               end else if (bus.ready_i) begin
                  r_state <= EMPTY;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rr_mux_arbiter_if #(.DATA_W(8)) bus ();

   rr_mux_arbiter #(.DATA_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: output stage contents and rotating priority as plain integers.
   int         m_ptr;
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   bit         m_started;

   function automatic int model_winner();
      if (rst || bus.req_i == 4'b0000 || (m_valid && !bus.ready_i)) return -1;
      for (int off = 0; off < 4; off++) begin
         if (bus.req_i[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_grant();
      int w;
      w = model_winner();
      if (w < 0) return 4'b0000;
      return 4'(1 << w);
   endfunction

   always @(posedge clk) begin
      int w;
      w = model_winner();
      if (rst) begin
         m_valid   = 1'b0;
         m_data    = 8'h00;
         m_sel     = 0;
         m_ptr     = 0;
         m_started = 1'b1;
      end else if (w >= 0) begin
         m_valid = 1'b1;
         m_data  = bus.data_i[w*8 +: 8];
         m_sel   = w;
         m_ptr   = (w + 1) % 4;
      end else if (m_valid && bus.ready_i) begin
         m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("model_grant", 32'(bus.grant_o), 32'(model_grant()));
         check("model_valid", 32'(bus.valid_o), 32'(m_valid));
         check("model_data",  32'(bus.data_o),  32'(m_data));
         check("model_sel",   32'(bus.sel_o),   32'(m_sel));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rot_words [4];

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      m_started   = 1'b0;
      m_ptr       = 0;
      m_valid     = 1'b0;
      m_data      = 8'h00;
      m_sel       = 0;
      rot_words[0] = 8'h10;
      rot_words[1] = 8'h21;
      rot_words[2] = 8'h32;
      rot_words[3] = 8'h43;
      rst          = 1'b1;
      bus.req_i    = 4'b0000;
      bus.ready_i  = 1'b1;
      bus.data_i   = 32'h0;

      // Reset then idle
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("idle_valid", 32'(bus.valid_o), 32'd0);
         check("idle_data",  32'(bus.data_o),  32'd0);
         check("idle_sel",   32'(bus.sel_o),   32'd0);
         check("idle_grant", 32'(bus.grant_o), 32'd0);
         tick();
      end

      // Single request from requester 2
      bus.data_i[2*8 +: 8] = 8'hA5;
      bus.req_i = 4'b0100;
      #1;
      check("single_grant", 32'(bus.grant_o), 32'h4);
      tick();
      bus.req_i = 4'b0000;
      #1;
      check("single_valid", 32'(bus.valid_o), 32'd1);
      check("single_data",  32'(bus.data_o),  32'hA5);
      check("single_sel",   32'(bus.sel_o),   32'd2);
      tick();

      // Full rotation from ptr=0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) bus.data_i[k*8 +: 8] = rot_words[k];
      bus.req_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rot_grant", 32'(bus.grant_o), 32'(1 << (k % 4)));
         tick();
         check("rot_sel",  32'(bus.sel_o),  32'(k % 4));
         check("rot_data", 32'(bus.data_o), 32'(rot_words[k % 4]));
      end

      // Backpressure: ptr=1 now, load 0x55 from requester 1
      bus.data_i[1*8 +: 8] = 8'h55;
      bus.req_i = 4'b0010;
      #1;
      check("bp_load_grant", 32'(bus.grant_o), 32'h2);
      tick();
      bus.ready_i = 1'b0;
      bus.req_i   = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_grant", 32'(bus.grant_o), 32'd0);
         check("bp_data",  32'(bus.data_o),  32'h55);
         check("bp_valid", 32'(bus.valid_o), 32'd1);
         check("bp_sel",   32'(bus.sel_o),   32'd1);
         tick();
      end
      bus.ready_i = 1'b1;
      #1;
      check("bp_rel_grant3", 32'(bus.grant_o), 32'h8);
      tick();
      check("bp_rel_sel3",  32'(bus.sel_o),  32'd3);
      check("bp_rel_data3", 32'(bus.data_o), 32'h43);
      check("bp_rel_grant0", 32'(bus.grant_o), 32'h1);
      tick();
      check("bp_rel_sel0",  32'(bus.sel_o),  32'd0);
      check("bp_rel_data0", 32'(bus.data_o), 32'h10);

      // Wrap-around: ptr=1, grant requester 3, then 4'b0011 -> 0 then 1
      bus.req_i = 4'b1000;
      #1;
      check("wrap_grant3", 32'(bus.grant_o), 32'h8);
      tick();
      bus.req_i = 4'b0011;
      #1;
      check("wrap_grant0", 32'(bus.grant_o), 32'h1);
      tick();
      check("wrap_sel0", 32'(bus.sel_o), 32'd0);
      check("wrap_grant1", 32'(bus.grant_o), 32'h2);
      tick();
      check("wrap_sel1", 32'(bus.sel_o), 32'd1);

      // Reset mid-transfer
      bus.req_i   = 4'b0000;
      bus.ready_i = 1'b0;
      tick();
      check("mid_hold_valid", 32'(bus.valid_o), 32'd1);
      rst       = 1'b1;
      bus.req_i = 4'b1111;
      bus.ready_i = 1'b1;
      #1;
      check("rst_grant_zero", 32'(bus.grant_o), 32'd0);
      tick();
      rst       = 1'b0;
      bus.req_i = 4'b1010;
      bus.ready_i = 1'b0;
      #1;
      check("mid_valid", 32'(bus.valid_o), 32'd0);
      check("mid_sel",   32'(bus.sel_o),   32'd0);
      check("mid_data",  32'(bus.data_o),  32'd0);
      check("mid_grant", 32'(bus.grant_o), 32'h2);
      tick();
      check("mid_win_sel",  32'(bus.sel_o),  32'd1);
      check("mid_win_data", 32'(bus.data_o), 32'h55);

      bus.req_i   = 4'b0000;
      bus.ready_i = 1'b1;
      tick();
      tick();
      check("drain_valid", 32'(bus.valid_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
